// File: rtl/clock_divider_sequencer_pkg.sv
// Shared definitions for the divided-clock sequencer: sequencer state
// encoding and default sizing of the divide counter and divisor.
package clock_divider_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } seq_state_t;

  localparam int DEFAULT_WIDTH       = 28;
  localparam int DEFAULT_DIVISOR     = 4;
  localparam int DEFAULT_MIN_DIVISOR = 2;

endpackage

// File: rtl/clock_divider_sequencer_divider_counter.sv
// Divide counter for the divided-clock datapath.
// Counts 0..divisor-1 while enabled, flags the last cycle of each period and
// produces registered clockOut/tick decodes for the cycle being entered.
//
// Ports:
//   clockIn      - sole clock, rising edge
//   i_clear      - synchronous clear of counter and decodes
//   i_enable     - divided clock runs in the coming cycle
//   i_divisor    - divisor currently in effect
//   o_boundary   - current cycle is the last one of a running period
//   o_clock_out  - divided clock
//   o_tick       - high on the first cycle of each divided period
module clock_divider_sequencer_divider_counter
  import clock_divider_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clockIn,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_boundary,
  output logic             o_clock_out,
  output logic             o_tick
);

  logic             r_active;
  logic [WIDTH-1:0] r_counter;
  logic             r_clock_out;
  logic             r_tick;
  logic             w_boundary;
  logic [WIDTH-1:0] w_counter_next;

  assign w_boundary = r_active && (r_counter == (i_divisor - WIDTH'(1)));

  // Entering a run from idle starts at 0 rather than incrementing, so the
  // first running cycle is always the start of a fresh period.
  always_comb begin
    w_counter_next = '0;
    if (i_enable && r_active && !w_boundary) begin
      w_counter_next = r_counter + WIDTH'(1);
    end
  end

  // The decode uses the current divisor: a new divisor only takes effect when
  // the next counter value is 0, and 0 decodes low for any legal divisor.
  always_ff @(posedge clockIn) begin
    if (i_clear) begin
      r_active    <= 1'b0;
      r_counter   <= '0;
      r_clock_out <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_active    <= i_enable;
      r_counter   <= w_counter_next;
      r_clock_out <= i_enable && (w_counter_next >= (i_divisor >> 1));
      r_tick      <= i_enable && (w_counter_next == '0);
    end
  end

  assign o_boundary  = w_boundary;
  assign o_clock_out = r_clock_out;
  assign o_tick      = r_tick;

endmodule

// File: rtl/clock_divider_sequencer.sv
// Run/stop and reconfiguration controller for the divided-clock datapath.
// New divisors arrive over a valid/ready handshake and are applied only at
// period boundaries so clockOut never produces runt pulses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | divided clock halted, counter held at 0, clockOut low
// RUN      | divided clock running
// STOPPING | running until the end of the current period, then IDLE
//
// Ports:
//   clockIn        - sole clock, rising edge
//   reset          - synchronous, active-high
//   start / stop   - level requests to run / halt at end of period
//   cfgValid/Ready - divisor offer handshake, cfgDivisor carries the value
//   cfgError       - one-cycle pulse when an accepted divisor was too small
//   clockOut, tick - divided clock and first-cycle-of-period pulse
//   running        - high in RUN or STOPPING
//   activeDivisor  - divisor currently in effect
module clock_divider_sequencer
  import clock_divider_sequencer_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DIVISOR     = DEFAULT_DIVISOR,
  parameter int MIN_DIVISOR = DEFAULT_MIN_DIVISOR
) (
  input  logic             clockIn,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfgValid,
  input  logic [WIDTH-1:0] cfgDivisor,
  output logic             cfgReady,
  output logic             cfgError,
  output logic             clockOut,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] activeDivisor
);

  seq_state_t       r_state;
  seq_state_t       w_state_next;
  logic [WIDTH-1:0] r_active_div;
  logic [WIDTH-1:0] r_pending_div;
  logic             r_pending_flag;
  logic             r_cfg_error;
  logic             w_boundary;
  logic             w_accept;
  logic             w_div_legal;
  logic             w_run_next;

  assign cfgReady    = !r_pending_flag && !reset;
  assign w_accept    = cfgValid && cfgReady;
  assign w_div_legal = (cfgDivisor >= WIDTH'(MIN_DIVISOR));
  assign w_run_next  = (w_state_next != ST_IDLE);

  always_ff @(posedge clockIn) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // stop always wins over a simultaneous start.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (stop) w_state_next = ST_STOPPING;
      end
      ST_STOPPING: begin
        if (start && !stop) w_state_next = ST_RUN;
        else if (w_boundary) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A pending divisor and a new acceptance never coincide: acceptance needs
  // the pending slot empty, so an offer taken on a boundary cycle waits a
  // full period before it is applied.
  always_ff @(posedge clockIn) begin
    if (reset) begin
      r_active_div   <= WIDTH'(DIVISOR);
      r_pending_div  <= '0;
      r_pending_flag <= 1'b0;
      r_cfg_error    <= 1'b0;
    end else begin
      r_cfg_error <= w_accept && !w_div_legal;
      if (w_boundary && r_pending_flag) begin
        r_active_div   <= r_pending_div;
        r_pending_flag <= 1'b0;
      end
      if (w_accept && w_div_legal) begin
        if (r_state == ST_IDLE) begin
          r_active_div <= cfgDivisor;
        end else begin
          r_pending_div  <= cfgDivisor;
          r_pending_flag <= 1'b1;
        end
      end
    end
  end

  clock_divider_sequencer_divider_counter #(
    .WIDTH (WIDTH)
  ) u_divider_counter (
    .clockIn     (clockIn),
    .i_clear     (reset),
    .i_enable    (w_run_next),
    .i_divisor   (r_active_div),
    .o_boundary  (w_boundary),
    .o_clock_out (clockOut),
    .o_tick      (tick)
  );

  assign cfgError      = r_cfg_error;
  assign running       = (r_state != ST_IDLE);
  assign activeDivisor = r_active_div;

endmodule

// File: tb/tb_clock_divider_sequencer.sv
// Directed bench: each row gives the inputs held during one clockIn cycle and
// the outputs expected to be visible in that same cycle.
module tb_clock_divider_sequencer;

  localparam int WIDTH = 28;

  logic             clockIn;
  logic             reset;
  logic             start;
  logic             stop;
  logic             cfgValid;
  logic [WIDTH-1:0] cfgDivisor;
  logic             cfgReady;
  logic             cfgError;
  logic             clockOut;
  logic             tick;
  logic             running;
  logic [WIDTH-1:0] activeDivisor;

  clock_divider_sequencer #(
    .WIDTH       (WIDTH),
    .DIVISOR     (4),
    .MIN_DIVISOR (2)
  ) dut (
    .clockIn       (clockIn),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .cfgValid      (cfgValid),
    .cfgDivisor    (cfgDivisor),
    .cfgReady      (cfgReady),
    .cfgError      (cfgError),
    .clockOut      (clockOut),
    .tick          (tick),
    .running       (running),
    .activeDivisor (activeDivisor)
  );

  typedef struct {
    int               idx;
    logic             clk;
    logic             tk;
    logic             run;
    logic             rdy;
    logic             err;
    logic [WIDTH-1:0] div;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   row_idx = 0;

  initial clockIn = 1'b0;
  always #5 clockIn = ~clockIn;

  task automatic chk(input string name, input int idx, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s got %0d expected %0d", idx, name, act, exp);
    end
  endtask

  always @(negedge clockIn) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("clockOut", e.idx, WIDTH'(clockOut), WIDTH'(e.clk));
      chk("tick", e.idx, WIDTH'(tick), WIDTH'(e.tk));
      chk("running", e.idx, WIDTH'(running), WIDTH'(e.run));
      chk("cfgReady", e.idx, WIDTH'(cfgReady), WIDTH'(e.rdy));
      chk("cfgError", e.idx, WIDTH'(cfgError), WIDTH'(e.err));
      chk("activeDivisor", e.idx, activeDivisor, e.div);
    end
  end

  task automatic row(input logic rst, input logic st, input logic sp, input logic cv,
                     input int cd, input logic eclk, input logic etk, input logic erun,
                     input logic erdy, input logic eerr, input int ediv);
    exp_t e;
    @(posedge clockIn);
    #1;
    reset      = rst;
    start      = st;
    stop       = sp;
    cfgValid   = cv;
    cfgDivisor = WIDTH'(cd);
    e.idx = row_idx;
    e.clk = eclk;
    e.tk  = etk;
    e.run = erun;
    e.rdy = erdy;
    e.err = eerr;
    e.div = WIDTH'(ediv);
    exp_q.push_back(e);
    row_idx++;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    cfgValid   = 1'b0;
    cfgDivisor = '0;
    //  rst st sp cv cd   clk tk run rdy err div
    row(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 4);   // 0  in reset
    row(0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 4);   // 1  idle, start raised
    row(0, 1, 0, 0, 0,   0, 1, 1, 1, 0, 4);   // 2  c0
    row(0, 1, 0, 0, 0,   0, 0, 1, 1, 0, 4);   // 3  c1
    row(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 4);   // 4  c2
    row(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 4);   // 5  c3
    row(0, 1, 0, 0, 0,   0, 1, 1, 1, 0, 4);   // 6  c0
    row(0, 1, 0, 1, 6,   0, 0, 1, 1, 0, 4);   // 7  c1 offer 6, accepted
    row(0, 1, 0, 1, 8,   1, 0, 1, 0, 0, 4);   // 8  c2 offer 8, blocked
    row(0, 1, 0, 1, 8,   1, 0, 1, 0, 0, 4);   // 9  c3 boundary
    row(0, 1, 0, 1, 8,   0, 1, 1, 1, 0, 6);   // 10 c0 D6, 8 accepted
    row(0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 6);   // 11 c1
    row(0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 6);   // 12 c2
    row(0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 6);   // 13 c3
    row(0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 6);   // 14 c4
    row(0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 6);   // 15 c5 boundary
    row(0, 1, 0, 0, 0,   0, 1, 1, 1, 0, 8);   // 16 c0 D8
    row(0, 1, 0, 0, 0,   0, 0, 1, 1, 0, 8);   // 17 c1
    row(0, 1, 0, 0, 0,   0, 0, 1, 1, 0, 8);   // 18 c2
    row(0, 1, 0, 0, 0,   0, 0, 1, 1, 0, 8);   // 19 c3
    row(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 8);   // 20 c4
    row(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 8);   // 21 c5
    row(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 8);   // 22 c6
    row(0, 1, 0, 1, 4,   1, 0, 1, 1, 0, 8);   // 23 c7 boundary, offer 4
    row(0, 1, 0, 0, 0,   0, 1, 1, 0, 0, 8);   // 24 c0 still D8
    row(0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 8);   // 25 c1
    row(0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 8);   // 26 c2
    row(0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 8);   // 27 c3
    row(0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 8);   // 28 c4
    row(0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 8);   // 29 c5
    row(0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 8);   // 30 c6
    row(0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 8);   // 31 c7 boundary
    row(0, 1, 0, 0, 0,   0, 1, 1, 1, 0, 4);   // 32 c0 D4
    row(0, 1, 0, 0, 0,   0, 0, 1, 1, 0, 4);   // 33 c1
    row(0, 0, 1, 0, 0,   1, 0, 1, 1, 0, 4);   // 34 c2 stop
    row(0, 0, 1, 0, 0,   1, 0, 1, 1, 0, 4);   // 35 c3 stopping
    row(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 4);   // 36 idle
    row(0, 1, 1, 0, 0,   0, 0, 0, 1, 0, 4);   // 37 start with stop
    row(0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 4);   // 38 still idle
    row(0, 1, 0, 0, 0,   0, 1, 1, 1, 0, 4);   // 39 c0
    row(0, 1, 0, 0, 0,   0, 0, 1, 1, 0, 4);   // 40 c1
    row(0, 0, 1, 0, 0,   1, 0, 1, 1, 0, 4);   // 41 c2 stop
    row(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 4);   // 42 c3 stopping, restart
    row(0, 1, 0, 0, 0,   0, 1, 1, 1, 0, 4);   // 43 c0 no gap
    row(0, 1, 0, 0, 0,   0, 0, 1, 1, 0, 4);   // 44 c1
    row(0, 1, 0, 1, 1,   1, 0, 1, 1, 0, 4);   // 45 c2 offer 1
    row(0, 1, 0, 0, 0,   1, 0, 1, 1, 1, 4);   // 46 c3 error pulse
    row(0, 1, 0, 0, 0,   0, 1, 1, 1, 0, 4);   // 47 c0
    row(0, 1, 0, 1, 9,   0, 0, 1, 1, 0, 4);   // 48 c1 offer 9
    row(1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 4);   // 49 c2 reset raised
    row(1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 4);   // 50 in reset
    row(0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 4);   // 51 reset dropped
    row(0, 1, 0, 0, 0,   0, 1, 1, 1, 0, 4);   // 52 c0
    row(0, 1, 0, 0, 0,   0, 0, 1, 1, 0, 4);   // 53 c1
    row(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 4);   // 54 c2
    row(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 4);   // 55 c3
    row(0, 0, 1, 0, 0,   0, 1, 1, 1, 0, 4);   // 56 c0 D4 kept, stop
    row(0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 4);   // 57 c1 stopping
    row(0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 4);   // 58 c2
    row(0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 4);   // 59 c3
    row(0, 0, 0, 1, 5,   0, 0, 0, 1, 0, 4);   // 60 idle, offer 5
    row(0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 5);   // 61 idle D5, start
    row(0, 1, 0, 0, 0,   0, 1, 1, 1, 0, 5);   // 62 c0
    row(0, 1, 0, 0, 0,   0, 0, 1, 1, 0, 5);   // 63 c1
    row(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 5);   // 64 c2
    row(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 5);   // 65 c3
    row(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 5);   // 66 c4
    row(0, 1, 0, 0, 0,   0, 1, 1, 1, 0, 5);   // 67 c0
    row(0, 1, 0, 0, 0,   0, 0, 1, 1, 0, 5);   // 68 c1
    row(0, 1, 0, 0, 0,   1, 0, 1, 1, 0, 5);   // 69 c2

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clockIn);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain %0d rows left unchecked, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
